multicycle_ctrl: RTL and testbench

- FSM controller that sequences the shared MIPS multicycle datapath: one ALU, one unified instruction/data memory port, IR, PC, ALUOut and MDR.
- Replaces per-instruction combinational control with FETCH/DECODE/EXEC/MEM/WB sequencing.
- Supports a memory ready handshake so memory may insert wait states.
- Sits between the IR/ALU flags and every datapath mux/enable.

---
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared-resource MIPS multicycle datapath.
// Only state and illegal are flops; every other output is decoded from the current state and inputs.
module multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        alu_neg,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [2:0]  ALUSrcB,
  output logic [3:0]  ALU_ctrl,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001, OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011, OP_BEQ    = 6'b000100, OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111, OP_ADDI   = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010, OP_ANDI   = 6'b001100, OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111, OP_LW     = 6'b100011, OP_SW   = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA  = 6'b000011, F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND = 6'b100100, F_OR  = 6'b100101, F_NOR  = 6'b100111, F_SLT  = 6'b101010;

  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_LUI = 4'd10;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [5:0] opcode, funct;
  logic [4:0] rt, rd;
  logic       r_valid;
  logic [3:0] r_alu;
  logic       unused_fields;

  assign opcode        = instruction[31:26];
  assign rt            = instruction[20:16];
  assign rd            = instruction[15:11];
  assign funct         = instruction[5:0];
  assign unused_fields = ^{instruction[25:21], instruction[10:6]};

  always_comb begin
    r_valid = 1'b1;
    r_alu   = ALU_NOP;
    case (funct)
      F_SLL:          r_alu = (rd == 5'd0) ? ALU_NOP : ALU_SLL;
      F_SRL:          r_alu = ALU_SRL;
      F_SRA:          r_alu = ALU_SRA;
      F_ADD, F_ADDU:  r_alu = ALU_ADD;
      F_SUB, F_SUBU:  r_alu = ALU_SUB;
      F_AND:          r_alu = ALU_AND;
      F_OR:           r_alu = ALU_OR;
      F_NOR:          r_alu = ALU_NOR;
      F_SLT:          r_alu = ALU_SLT;
      default:        r_valid = 1'b0;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;  PCSrc    = 2'b00;  IorD     = 1'b0;  MemRead  = 1'b0;
    MemWrite  = 1'b0;  IRWrite  = 1'b0;   RegWrite = 1'b0;  RegDst   = 2'b00;
    MemtoReg  = 2'b00; ALUSrcA  = 1'b0;   ALUSrcB  = 3'b000; ALU_ctrl = ALU_NOP;
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 3'b001;
        ALU_ctrl = ALU_ADD;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB  = 3'b100;
        ALU_ctrl = ALU_ADD;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_RTYPE: begin
            if (funct == F_JR) begin
              PCSrc   = 2'b11;
              PCWrite = 1'b1;
            end else if (r_valid) begin
              ALUSrcA  = 1'b1;
              ALU_ctrl = r_alu;
              state_d  = S_WB;
            end else begin
              illegal_d = 1'b1;
            end
          end
          OP_ADDI, OP_ADDIU: begin ALUSrcA = 1'b1; ALUSrcB = 3'b010; ALU_ctrl = ALU_ADD; state_d = S_WB; end
          OP_SLTI:           begin ALUSrcA = 1'b1; ALUSrcB = 3'b010; ALU_ctrl = ALU_SLT; state_d = S_WB; end
          OP_ANDI:           begin ALUSrcA = 1'b1; ALUSrcB = 3'b011; ALU_ctrl = ALU_AND; state_d = S_WB; end
          OP_ORI:            begin ALUSrcA = 1'b1; ALUSrcB = 3'b011; ALU_ctrl = ALU_OR;  state_d = S_WB; end
          OP_LUI:            begin ALUSrcA = 1'b1; ALUSrcB = 3'b011; ALU_ctrl = ALU_LUI; state_d = S_WB; end
          OP_LW, OP_SW:      begin ALUSrcA = 1'b1; ALUSrcB = 3'b010; ALU_ctrl = ALU_ADD; state_d = S_MEM; end
          // Branch target was computed into ALUOut during DECODE
          OP_BEQ:  begin ALUSrcA = 1'b1; ALU_ctrl = ALU_SUB; PCSrc = 2'b01; PCWrite = zero;  end
          OP_BNE:  begin ALUSrcA = 1'b1; ALU_ctrl = ALU_SUB; PCSrc = 2'b01; PCWrite = !zero; end
          OP_BGTZ: begin
            ALUSrcA = 1'b1; ALUSrcB = 3'b101; ALU_ctrl = ALU_SUB; PCSrc = 2'b01;
            PCWrite = !alu_neg && !zero;
          end
          OP_REGIMM: begin
            if (rt == 5'd1) begin
              ALUSrcA = 1'b1; ALUSrcB = 3'b101; ALU_ctrl = ALU_SUB; PCSrc = 2'b01;
              PCWrite = !alu_neg;
            end else begin
              illegal_d = 1'b1;
            end
          end
          OP_J:    begin PCSrc = 2'b10; PCWrite = 1'b1; end
          // PC already holds PC+4 here, which is the link value written to $31
          OP_JAL:  begin PCSrc = 2'b10; PCWrite = 1'b1; RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10; end
          default: illegal_d = 1'b1;
        endcase
      end
      S_MEM: begin
        IorD = 1'b1;
        if (opcode == OP_LW) begin
          MemRead = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else begin
          MemWrite = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        if (opcode != OP_RTYPE) RegDst   = 2'b01;
        if (opcode == OP_LW)    MemtoReg = 2'b01;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset must silence the decoded outputs immediately, not just at the next edge
    if (!reset_n) begin
      PCWrite  = 1'b0;  PCSrc    = 2'b00;  IorD     = 1'b0;  MemRead  = 1'b0;
      MemWrite = 1'b0;  IRWrite  = 1'b0;   RegWrite = 1'b0;  RegDst   = 2'b00;
      MemtoReg = 2'b00; ALUSrcA  = 1'b0;   ALUSrcB  = 3'b000; ALU_ctrl = ALU_NOP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= state_t'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions then random ones, each expanded into
// its expected per-cycle phase list and control word by an instruction-level model.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instruction;
  logic        zero, alu_neg, mem_ready;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, illegal;
  logic [1:0]  PCSrc, RegDst, MemtoReg;
  logic [2:0]  ALUSrcB, state;
  logic [3:0]  ALU_ctrl;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .zero(zero), .alu_neg(alu_neg),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_ctrl(ALU_ctrl),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;  logic [1:0] pcsrc; logic iord; logic mrd; logic mwr; logic irw; logic rw;
    logic [1:0] rdst; logic [1:0] m2r;   logic srca; logic [2:0] srcb; logic [3:0] alu;
  } ctl_t;

  typedef enum {K_R, K_JR, K_ALUI, K_LW, K_SW, K_BR, K_J, K_JAL, K_ILL} kind_t;

  int   total = 0;
  int   bad   = 0;
  logic exp_ill = 1'b0;

  function automatic kind_t kind_of(input logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    if (op == 6'd0) begin
      if (fn == 6'd8) return K_JR;
      if (fn inside {6'd0, 6'd2, 6'd3, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd39, 6'd42}) return K_R;
      return K_ILL;
    end
    if (op == 6'd1) return (ins[20:16] == 5'd1) ? K_BR : K_ILL;
    if (op inside {6'd4, 6'd5, 6'd7}) return K_BR;
    if (op inside {6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd15}) return K_ALUI;
    if (op == 6'd2)  return K_J;
    if (op == 6'd3)  return K_JAL;
    if (op == 6'd35) return K_LW;
    if (op == 6'd43) return K_SW;
    return K_ILL;
  endfunction

  // Expected control word for one cycle of an instruction in phase ph (0..4)
  function automatic ctl_t exp_ctl(input int ph, input logic [31:0] ins, input logic z,
                                   input logic n, input logic mr);
    ctl_t  c = '0;
    kind_t k = kind_of(ins);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    case (ph)
      0: begin c.mrd = 1; c.srcb = 3'd1; c.alu = 4'd1; c.irw = mr; c.pcw = mr; end
      1: begin c.srcb = 3'd4; c.alu = 4'd1; end
      2: case (k)
        K_R: begin
          c.srca = 1;
          case (fn)
            6'd0:         c.alu = (ins[15:11] == 0) ? 4'd0 : 4'd7;
            6'd2:         c.alu = 4'd8;
            6'd3:         c.alu = 4'd9;
            6'd32, 6'd33: c.alu = 4'd1;
            6'd34, 6'd35: c.alu = 4'd2;
            6'd36:        c.alu = 4'd3;
            6'd37:        c.alu = 4'd4;
            6'd39:        c.alu = 4'd5;
            default:      c.alu = 4'd6;
          endcase
        end
        K_JR: begin c.pcsrc = 2'd3; c.pcw = 1; end
        K_ALUI: begin
          c.srca = 1;
          case (op)
            6'd10:   begin c.srcb = 3'd2; c.alu = 4'd6;  end
            6'd12:   begin c.srcb = 3'd3; c.alu = 4'd3;  end
            6'd13:   begin c.srcb = 3'd3; c.alu = 4'd4;  end
            6'd15:   begin c.srcb = 3'd3; c.alu = 4'd10; end
            default: begin c.srcb = 3'd2; c.alu = 4'd1;  end
          endcase
        end
        K_LW, K_SW: begin c.srca = 1; c.srcb = 3'd2; c.alu = 4'd1; end
        K_BR: begin
          c.srca = 1; c.alu = 4'd2; c.pcsrc = 2'd1;
          case (op)
            6'd4:    c.pcw = z;
            6'd5:    c.pcw = !z;
            6'd7:    begin c.srcb = 3'd5; c.pcw = !n && !z; end
            default: begin c.srcb = 3'd5; c.pcw = !n; end
          endcase
        end
        K_J:   begin c.pcsrc = 2'd2; c.pcw = 1; end
        K_JAL: begin c.pcsrc = 2'd2; c.pcw = 1; c.rw = 1; c.rdst = 2'd2; c.m2r = 2'd2; end
        default: ;
      endcase
      3: begin c.iord = 1; c.mrd = (k == K_LW); c.mwr = (k == K_SW); end
      4: begin c.rw = 1; c.rdst = (k == K_R) ? 2'd0 : 2'd1; c.m2r = (k == K_LW) ? 2'd1 : 2'd0; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic ctl_t obs_ctl();
    return {PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
            ALUSrcA, ALUSrcB, ALU_ctrl};
  endfunction

  // One clock of an instruction: drive on the falling edge, check 1 time unit later
  task automatic step(input int ph, input logic mr, input logic z, input logic n, input logic [31:0] ins);
    @(negedge clk);
    instruction = ins; mem_ready = mr; zero = z; alu_neg = n;
    #1;
    chk($sformatf("state ins=%h", ins), 32'(state), 32'(ph));
    chk($sformatf("illegal ins=%h ph=%0d", ins, ph), 32'(illegal), 32'(exp_ill));
    chk($sformatf("ctl ins=%h ph=%0d", ins, ph), 32'(obs_ctl()), 32'(exp_ctl(ph, ins, z, n, mr)));
    exp_ill = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic z, input logic n,
                           input int wf, input int wm, input bit abort_mem);
    kind_t k = kind_of(ins);
    int    cyc = 0;
    for (int i = 0; i < wf; i++) begin step(0, 1'b0, 1'($urandom), 1'($urandom), ins); cyc++; end
    step(0, 1'b1, 1'($urandom), 1'($urandom), ins); cyc++;
    step(1, 1'($urandom), 1'($urandom), 1'($urandom), ins); cyc++;
    step(2, 1'($urandom), z, n, ins); cyc++;
    if (k == K_ILL) exp_ill = 1'b1;
    if (k == K_LW || k == K_SW) begin
      if (abort_mem) begin
        step(3, 1'b0, 1'b0, 1'b0, ins);
        reset_n = 1'b0;
        #1;
        chk("abort state", 32'(state), 32'd0);
        chk("abort ctl", 32'(obs_ctl()), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        $display("ins=%h aborted in MEM by reset", ins);
        return;
      end
      for (int i = 0; i < wm; i++) begin step(3, 1'b0, 1'($urandom), 1'($urandom), ins); cyc++; end
      step(3, 1'b1, 1'($urandom), 1'($urandom), ins); cyc++;
    end
    if (k == K_R || k == K_ALUI || k == K_LW) begin step(4, 1'($urandom), 1'($urandom), 1'($urandom), ins); cyc++; end
    $display("ins=%h kind=%s z=%0b n=%0b fetch_wait=%0d mem_wait=%0d cycles=%0d", ins, k.name(), z, n, wf, wm, cyc);
  endtask

  logic [5:0] ops [20] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7, 6'd8, 6'd9,
                           6'd10, 6'd12, 6'd13, 6'd15, 6'd35, 6'd43, 6'd63, 6'd16, 6'd14};
  logic [5:0] fns [15] = '{6'd0, 6'd2, 6'd3, 6'd8, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37,
                           6'd39, 6'd42, 6'd9, 6'd4, 6'd63};

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; alu_neg = 1'b0; instruction = 32'h8C850008;
    repeat (3) begin
      @(negedge clk); #1;
      chk("reset state", 32'(state), 32'd0);
      chk("reset ctl", 32'(obs_ctl()), 32'd0);
      chk("reset illegal", 32'(illegal), 32'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_instr(32'h00221820, 1'b0, 1'b0, 0, 0, 0);   // add $3,$1,$2
    run_instr(32'h8C850008, 1'b0, 1'b0, 0, 2, 0);   // lw $5,8($4), two MEM waits
    run_instr(32'h10220003, 1'b1, 1'b0, 0, 0, 0);   // beq taken
    run_instr(32'h10220003, 1'b0, 1'b0, 1, 0, 0);   // beq not taken, one fetch wait
    run_instr(32'h0C000040, 1'b0, 1'b0, 0, 0, 0);   // jal
    run_instr(32'hFC000000, 1'b0, 1'b0, 0, 0, 0);   // unsupported opcode
    run_instr(32'h00000000, 1'b0, 1'b0, 0, 0, 0);   // sll $0 nop
    run_instr(32'h04210002, 1'b0, 1'b1, 0, 0, 0);   // bgez, negative
    run_instr(32'h04200002, 1'b0, 1'b0, 0, 0, 0);   // regimm rt=0 unsupported
    run_instr(32'h1C200002, 1'b1, 1'b0, 0, 0, 0);   // bgtz, zero
    run_instr(32'hAC850008, 1'b0, 1'b0, 0, 1, 0);   // sw, one MEM wait
    run_instr(32'hAC850008, 1'b0, 1'b0, 0, 0, 1);   // sw aborted by reset
    run_instr(32'h03E00008, 1'b0, 1'b0, 0, 0, 0);   // jr $31

    for (int t = 0; t < 250; t++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 19)];
      if (ins[31:26] == 6'd0) ins[5:0] = fns[$urandom_range(0, 14)];
      if (ins[31:26] == 6'd1 && $urandom_range(0, 2) != 0) ins[20:16] = 5'd1;
      if ($urandom_range(0, 7) == 0) ins[15:11] = 5'd0;
      run_instr(ins, 1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    @(negedge clk); mem_ready = 1'b0; #1;
    chk("final state", 32'(state), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
